// File: rtl/framer_pkg.sv
// Shared types and constants for the trigger framer.
//   framer_state_t : frame state machine encoding
//   HDR_MAGIC      : upper half of the optional frame header word
//   CNT_W          : width of the frame word counter and trigger counter
package framer_pkg;
  typedef enum logic [1:0] {IDLE, DELAY, CAPTURE, DRAIN} framer_state_t;
  localparam logic [15:0] HDR_MAGIC = 16'hA5E5;
  localparam int CNT_W = 16;
endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXIS skid buffer carrying {tlast, tdata}.
//   clk, rst              : clock, asynchronous active-high reset
//   s_valid_i/s_data_i/s_last_i/s_ready_o : upstream side
//   m_valid_o/m_data_o/m_last_o/m_ready_i : downstream side
// Outputs come straight from storage, so a word pushed into an empty buffer
// appears one cycle later and holds steady while stalled. Room is reported
// when full if the head is leaving in the same cycle, so a held-high
// downstream ready sees an unbroken stream.
module axis_skid_buffer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid_i,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_last_i,
  output logic              s_ready_o,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  input  logic              m_ready_i
);
  logic [DATA_W:0] mem_q [2];
  logic            wr_q, rd_q;
  logic [1:0]      cnt_q;
  logic            push, pop;

  assign m_valid_o             = (cnt_q != 2'd0);
  assign {m_last_o, m_data_o}  = mem_q[rd_q];
  assign s_ready_o             = (cnt_q != 2'd2) | m_ready_i;
  assign push                  = s_valid_i & s_ready_o;
  assign pop                   = m_valid_o & m_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= {s_last_i, s_data_i};
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/trigger_framer.sv
// Cuts a free-running ADC AXI-Stream into fixed-length, trigger-aligned
// packets (tlast on the final word); words outside a frame are dropped.
//   s00_axis_aclk/areset : clock, asynchronous active-high reset
//   trig_in              : synchronous trigger level; a rising edge starts a frame
//   s00_axis_*           : ADC input stream
//   m00_axis_*           : framed output stream (tstrb constant all-ones)
//   trig_count           : frames started, wraps silently
//   overrun              : sticky, a trigger edge arrived while a frame was busy
// Build option FRAMER_HEADER_EN: prefix every frame with {HDR_MAGIC, trig_count}.
module trigger_framer
  import framer_pkg::*;
#(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int FRAME_WORDS            = 1024,
  parameter int DELAY_WORDS            = 0
) (
  input  logic                                s00_axis_aclk,
  input  logic                                s00_axis_areset,
  input  logic                                trig_in,
  input  logic                                s00_axis_tvalid,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  output logic                                s00_axis_tready,
  output logic                                m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                                m00_axis_tlast,
  input  logic                                m00_axis_tready,
  output logic [15:0]                         trig_count,
  output logic                                overrun
);
  framer_state_t                     state_q;
  logic [CNT_W-1:0]                  cnt_q, trig_count_q;
  logic                              trig_q, overrun_q, trig_edge;
  logic                              push_vld, push_last, sb_ready;
  logic [C_S00_AXIS_TDATA_WIDTH-1:0] push_data;
  logic                              frame_end;
`ifdef FRAMER_HEADER_EN
  logic                              hdr_pend_q;
`endif

  assign trig_edge      = trig_in & ~trig_q;
  assign trig_count     = trig_count_q;
  assign overrun        = overrun_q;
  assign m00_axis_tstrb = '1;
  assign frame_end      = (cnt_q == CNT_W'(FRAME_WORDS - 1));

  always_comb begin
    s00_axis_tready = 1'b1;
    push_vld        = 1'b0;
    push_data       = s00_axis_tdata;
    push_last       = 1'b0;
    if (state_q == CAPTURE) begin
`ifdef FRAMER_HEADER_EN
      if (hdr_pend_q) begin
        // header slot: hold the ADC stream for this cycle
        s00_axis_tready = 1'b0;
        push_vld        = 1'b1;
        push_data       = {HDR_MAGIC, trig_count_q};
      end else begin
        s00_axis_tready = sb_ready;
        push_vld        = s00_axis_tvalid;
        push_last       = frame_end;
      end
`else
      s00_axis_tready = sb_ready;
      push_vld        = s00_axis_tvalid;
      push_last       = frame_end;
`endif
    end
  end

  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      trig_count_q <= '0;
      trig_q       <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef FRAMER_HEADER_EN
      hdr_pend_q   <= 1'b0;
`endif
    end else begin
      trig_q <= trig_in;
      if (trig_edge && state_q != IDLE) overrun_q <= 1'b1;
      case (state_q)
        IDLE: if (trig_edge) begin
          trig_count_q <= trig_count_q + 1'b1;
          cnt_q        <= '0;
          state_q      <= (DELAY_WORDS > 0) ? DELAY : CAPTURE;
`ifdef FRAMER_HEADER_EN
          hdr_pend_q   <= 1'b1;
`endif
        end
        DELAY: if (s00_axis_tvalid) begin
          if (cnt_q == CNT_W'(DELAY_WORDS - 1)) begin
            cnt_q   <= '0;
            state_q <= CAPTURE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        CAPTURE: begin
`ifdef FRAMER_HEADER_EN
          if (hdr_pend_q) begin
            if (sb_ready) hdr_pend_q <= 1'b0;
          end else
`endif
          if (s00_axis_tvalid && sb_ready) begin
            if (frame_end) state_q <= DRAIN;
            else           cnt_q   <= cnt_q + 1'b1;
          end
        end
        // last-tagged word leaving means the buffer is now empty
        DRAIN: if (m00_axis_tvalid && m00_axis_tready && m00_axis_tlast) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  axis_skid_buffer #(.DATA_W(C_S00_AXIS_TDATA_WIDTH)) u_skid (
    .clk       (s00_axis_aclk),
    .rst       (s00_axis_areset),
    .s_valid_i (push_vld),
    .s_data_i  (push_data),
    .s_last_i  (push_last),
    .s_ready_o (sb_ready),
    .m_valid_o (m00_axis_tvalid),
    .m_data_o  (m00_axis_tdata),
    .m_last_o  (m00_axis_tlast),
    .m_ready_i (m00_axis_tready)
  );
endmodule
